// File: rtl/timer_irq_source.sv
// Interval timer that raises i_timer and holds it until the CPU acknowledges.
// Optional overrun counter is built only when TIMER_IRQ_OVERRUN_EN is defined.
module timer_irq_source #(
    parameter int unsigned PRESC_W = 16,
    parameter int unsigned PER_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [7:0]       cfg_data,
    input  logic             s_interruption,
    input  logic             s_finish_interr,
    output logic             i_timer,
    output logic [7:0]       status,
    output logic [PER_W-1:0] count
);

    localparam logic [1:0] SelPeriod  = 2'd0;
    localparam logic [1:0] SelPrescLo = 2'd1;
    localparam logic [1:0] SelPrescHi = 2'd2;
    localparam logic [1:0] SelCtrl    = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StService
    } state_e;

    state_e state_q, state_d;

    logic [PER_W-1:0]   period_q, period_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               enable_q, enable_d;
    logic               oneshot_q, oneshot_d;
    logic [PRESC_W-1:0] psc_q, psc_d;
    logic [PER_W-1:0]   cnt_q, cnt_d;
    logic               i_timer_q;

    logic       ctrl_wr;
    logic       tick;
    logic       expire;
    logic [3:0] ovr_count;

    assign ctrl_wr = cfg_we && (cfg_sel == SelCtrl);
    assign tick    = enable_q && (psc_q == presc_q);
    assign expire  = tick && (cnt_q == period_q);

    // Configuration registers; a ctrl write beats the oneshot auto-disable.
    always_comb begin
        period_d  = period_q;
        presc_d   = presc_q;
        enable_d  = enable_q;
        oneshot_d = oneshot_q;
        if (expire && oneshot_q) begin
            enable_d = 1'b0;
        end
        if (cfg_we) begin
            unique case (cfg_sel)
                SelPeriod:  period_d = PER_W'(cfg_data);
                SelPrescLo: presc_d[7:0] = cfg_data;
                SelPrescHi: presc_d[PRESC_W-1:8] = cfg_data[PRESC_W-9:0];
                SelCtrl: begin
                    enable_d  = cfg_data[0];
                    oneshot_d = cfg_data[1];
                end
                default: ;
            endcase
        end
    end

    // While disabled the counters sit at zero, so an enable edge always starts from zero.
    always_comb begin
        psc_d = psc_q;
        cnt_d = cnt_q;
        if (!enable_q) begin
            psc_d = '0;
            cnt_d = '0;
        end else begin
            psc_d = tick ? '0 : psc_q + 1'b1;
            if (tick) begin
                cnt_d = expire ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (expire) begin
                    state_d = StAssert;
                end
            end
            StAssert: begin
                if (s_finish_interr) begin
                    state_d = StIdle;
                end else if (s_interruption) begin
                    state_d = StService;
                end
            end
            StService: begin
                if (s_finish_interr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            period_q  <= '0;
            presc_q   <= '0;
            enable_q  <= 1'b0;
            oneshot_q <= 1'b0;
            psc_q     <= '0;
            cnt_q     <= '0;
            i_timer_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            presc_q   <= presc_d;
            enable_q  <= enable_d;
            oneshot_q <= oneshot_d;
            psc_q     <= psc_d;
            cnt_q     <= cnt_d;
            i_timer_q <= (state_d != StIdle);
        end
    end

`ifdef TIMER_IRQ_OVERRUN_EN
    logic [3:0] ovr_q, ovr_d;
    logic       ovr_event;

    // An expiry while a request is still in flight is dropped and counted.
    assign ovr_event = expire && (state_q != StIdle);

    always_comb begin
        ovr_d = ovr_q;
        if (ctrl_wr && cfg_data[2]) begin
            ovr_d = '0;
        end else if (ovr_event && (ovr_q != 4'hF)) begin
            ovr_d = ovr_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr_count = ovr_q;
`else
    logic unused_ctrl_wr;
    assign unused_ctrl_wr = ctrl_wr;
    assign ovr_count      = 4'h0;
`endif

    logic unused_cfg;
    assign unused_cfg = ^cfg_data;

    assign i_timer = i_timer_q;
    assign status  = {ovr_count, (state_q == StService), i_timer_q, oneshot_q, enable_q};
    assign count   = cnt_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// Self-checking bench for timer_irq_source: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_timer_irq_source;
    localparam int unsigned PRESC_W = 16;
    localparam int unsigned PER_W   = 8;
`ifdef TIMER_IRQ_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [7:0]       cfg_data;
    logic             s_interruption;
    logic             s_finish_interr;
    logic             i_timer;
    logic [7:0]       status;
    logic [PER_W-1:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    timer_irq_source #(
        .PRESC_W(PRESC_W),
        .PER_W  (PER_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_we         (cfg_we),
        .cfg_sel        (cfg_sel),
        .cfg_data       (cfg_data),
        .s_interruption (s_interruption),
        .s_finish_interr(s_finish_interr),
        .i_timer        (i_timer),
        .status         (status),
        .count          (count)
    );

    // Behavioural model: integers for counters, request level 0=none 1=raised 2=in ISR.
    int m_period, m_presc, m_psc, m_cnt, m_ovr, m_req;
    bit m_en, m_os, m_valid = 1'b0;
    bit m_tick, m_exp;

    always @(posedge clk) begin
        if (reset) begin
            m_period = 0; m_presc = 0; m_psc = 0; m_cnt = 0; m_ovr = 0; m_req = 0;
            m_en = 1'b0; m_os = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_tick = m_en && (m_psc == m_presc);
            m_exp  = m_tick && (m_cnt == m_period);
            if (OVR) begin
                if (cfg_we && cfg_sel == 2'd3 && cfg_data[2]) m_ovr = 0;
                else if (m_exp && m_req != 0 && m_ovr < 15) m_ovr = m_ovr + 1;
            end
            if (!m_en) begin
                m_psc = 0;
                m_cnt = 0;
            end else if (m_tick) begin
                m_psc = 0;
                m_cnt = m_exp ? 0 : (m_cnt + 1) % (1 << PER_W);
            end else begin
                m_psc = (m_psc + 1) % (1 << PRESC_W);
            end
            if (m_req == 0) begin
                if (m_exp) m_req = 1;
            end else if (s_finish_interr) begin
                m_req = 0;
            end else if (m_req == 1 && s_interruption) begin
                m_req = 2;
            end
            if (m_exp && m_os) m_en = 1'b0;
            if (cfg_we) begin
                case (cfg_sel)
                    2'd0: m_period = int'(cfg_data) % (1 << PER_W);
                    2'd1: m_presc = (m_presc & ~255) | int'(cfg_data);
                    2'd2: m_presc = (m_presc & 255)
                                  | ((int'(cfg_data) % (1 << (PRESC_W - 8))) << 8);
                    default: begin
                        m_en = cfg_data[0];
                        m_os = cfg_data[1];
                    end
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [7:0] es;
        es = {4'(m_ovr), (m_req == 2), (m_req != 0), m_os, m_en};
        check("model_i_timer", 32'(i_timer), 32'(m_req != 0));
        check("model_status", 32'(status), 32'(es));
        check("model_count", 32'(count), 32'(m_cnt));
    endtask

    // Advance one clock and compare every output against the model just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (m_valid) compare_model();
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = data;
        cyc();
        cfg_we   = 1'b0;
    endtask

    task automatic ack();
        s_finish_interr = 1'b1;
        cyc();
        s_finish_interr = 1'b0;
    endtask

    task automatic wait_rise(input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            cyc();
            if (i_timer) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_highs(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            cyc();
            if (i_timer) highs++;
        end
    endtask

    int n;
    int r;

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
        s_interruption = 1'b0; s_finish_interr = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        check("reset_i_timer", 32'(i_timer), 32'd0);
        check("reset_status", 32'(status), 32'h00);
        check("reset_count", 32'(count), 32'd0);

        // presc=1, period=3: first rise 8 cycles after the enable edge
        wr(2'd1, 8'd1); wr(2'd2, 8'd0); wr(2'd0, 8'd3); wr(2'd3, 8'h01);
        repeat (7) cyc();
        check("t1_before_rise", 32'(i_timer), 32'd0);
        cyc();
        check("t1_rise", 32'(i_timer), 32'd1);
        check("t1_status_itimer", 32'(status[2]), 32'd1);
        check("t1_model_req", 32'(m_req), 32'd1);

        // service then ack; next rise 8 cycles after the first
        cyc(); cyc();
        s_interruption = 1'b1;
        cyc();
        s_interruption = 1'b0;
        check("t2_in_service", 32'(status[3]), 32'd1);
        ack();
        check("t2_ack_drop", 32'(i_timer), 32'd0);
        cyc(); cyc(); cyc();
        check("t2_before_rise2", 32'(i_timer), 32'd0);
        cyc();
        check("t2_rise2", 32'(i_timer), 32'd1);
        wr(2'd3, 8'h00);
        ack();

        // presc=0, period=1, never acked: overruns accumulate and saturate
        wr(2'd1, 8'd0); wr(2'd0, 8'd1); wr(2'd3, 8'h01);
        cyc(); cyc();
        check("t3_rise", 32'(i_timer), 32'd1);
        repeat (8) cyc();
        check("t3_ovr4", 32'(status[7:4]), OVR ? 32'd4 : 32'd0);
        repeat (30) cyc();
        check("t3_ovr_sat", 32'(status[7:4]), OVR ? 32'd15 : 32'd0);
        wr(2'd3, 8'h05);
        check("t3_ovr_clr", 32'(status[7:4]), 32'd0);
        check("t3_enable_kept", 32'(status[0]), 32'd1);
        wr(2'd3, 8'h00);
        ack();

        // oneshot, presc=0, period=2
        wr(2'd0, 8'd2); wr(2'd3, 8'h03);
        cyc(); cyc();
        check("t4_before_rise", 32'(i_timer), 32'd0);
        cyc();
        check("t4_rise", 32'(i_timer), 32'd1);
        check("t4_enable_cleared", 32'(status[0]), 32'd0);
        check("t4_oneshot_bit", 32'(status[1]), 32'd1);
        ack();
        count_highs(50, n);
        check("t4_no_rerise", 32'(n), 32'd0);

        // reset while in service
        wr(2'd3, 8'h01);
        wait_rise(20, n);
        check("t5_rise_delay", 32'(n), 32'd3);
        s_interruption = 1'b1;
        cyc();
        s_interruption = 1'b0;
        check("t5_in_service", 32'(status[3]), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t5_i_timer", 32'(i_timer), 32'd0);
        check("t5_status", 32'(status), 32'h00);
        check("t5_count", 32'(count), 32'd0);
        count_highs(20, n);
        check("t5_no_rise", 32'(n), 32'd0);

        // expiry every cycle, ack coincides with an expiry
        wr(2'd3, 8'h01);
        cyc();
        check("t6_rise", 32'(i_timer), 32'd1);
        ack();
        check("t6_ack_drop", 32'(i_timer), 32'd0);
        check("t6_ovr_on_ack", 32'(status[7:4]), OVR ? 32'd1 : 32'd0);
        cyc();
        check("t6_rerise", 32'(i_timer), 32'd1);
        wr(2'd3, 8'h00);
        ack();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(99);
            s_interruption  = ($urandom_range(3) == 0);
            s_finish_interr = ($urandom_range(5) == 0);
            reset           = ($urandom_range(499) == 0);
            if (r < 12) begin
                cfg_we  = 1'b1;
                cfg_sel = 2'($urandom_range(3));
                case (cfg_sel)
                    2'd0:    cfg_data = 8'($urandom_range(5));
                    2'd1:    cfg_data = 8'($urandom_range(3));
                    2'd2:    cfg_data = ($urandom_range(7) == 0) ? 8'd1 : 8'd0;
                    default: cfg_data = 8'($urandom);
                endcase
            end else begin
                cfg_we = 1'b0;
            end
            cyc();
        end
        cfg_we = 1'b0; reset = 1'b0;
        s_interruption = 1'b0; s_finish_interr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
